mm_run_ctrl: RTL
================

// Module: mm_run_ctrl
// PURPOSE
//  Run sequencer for the memory-mapped coprocessor output side. Holds a programmed
//  word count per output port, starts the per-port back-end write controllers,
//  counts their write strobes, stops each port on its count and raises a one-cycle
//  completion event when every active port has finished. Sits between the host
//  register file and the N_OUT output back-ends.
// PARAMETERS
//  N_OUT  2   number of output ports / back-ends sequenced (1..8)
//  CNT_W  16  width of size registers and word counters
//  TO_W   20  watchdog width, used only with MM_RUN_TIMEOUT_EN
// PORTS
//  aclk       in   1              clock, all logic on rising edge
//  areset     in   1              synchronous reset, active-high
//  cfg_we     in   1              write size register cfg_sel with cfg_size
//  cfg_sel    in   3              port index for cfg_we
//  cfg_size   in   CNT_W          words expected from port (0 = port unused)
//  start_req  in   1              host run request (level sampled in IDLE)
//  abort      in   1              host abort request
//  busy       out  1              run in progress (state != IDLE)
//  done_irq   out  1              one-cycle pulse when run completes or aborts
//  err        out  1              sticky: write strobe on an already-complete port
//  timeout    out  1              sticky: watchdog expired (0 without macro)
//  be_start   out  N_OUT          per-port start to back-ends
//  be_done    out  N_OUT          per-port one-cycle done to back-ends
//  be_wr      in   N_OUT          per-port write strobe (back-end wren)
// BEHAVIOUR
//  Reset: state IDLE; busy, done_irq, err, timeout, be_start, be_done = 0;
//   size regs and counters = 0.
//  Config: cfg_we writes size[cfg_sel] in IDLE only; ignored elsewhere; cfg_sel
//   >= N_OUT ignored.
//  FSM IDLE -> ARM -> RUN -> DONE -> IDLE.
//   IDLE: start_req=1 -> ARM next cycle. err/timeout cleared on this transition.
//   ARM (1 cycle): counters cleared, sizes latched to active copies; act[i] =
//    (size[i]!=0). -> RUN.
//   RUN: be_start[i] = act[i] & ~cmp[i] (registered). be_wr[i] with act[i]&~cmp[i]
//    increments cnt[i]; if cnt[i]+1 == size[i], cmp[i] set and be_done[i] pulses
//    the next cycle; be_start[i] drops in that same cycle. When all act ports are
//    cmp (or no port active) -> DONE.
//   DONE (1 cycle): done_irq=1, be_start=0. -> IDLE.
//  Latency: start_req at cycle t -> ARM t+1, be_start high t+2; all sizes zero
//   -> done_irq at t+3.
//  be_wr on inactive or completed port: not counted, err set (sticky).
//  Simultaneous completion of several ports in one cycle: all be_done pulse
//   together, DONE entered next cycle.
//  abort in ARM/RUN: next cycle be_start=0, be_done pulses for every act&~cmp
//   port, state DONE (done_irq pulses), then IDLE. abort in IDLE/DONE ignored.
//  Counters never wrap: count saturates at size. Reset mid-run returns to reset
//   values in one cycle; no be_done emitted.
// CONFIGURATION
//  MM_RUN_TIMEOUT_EN defined: TO_W-bit watchdog counts RUN cycles with no counted
//   be_wr, cleared by any counted write and on entering RUN; at 2^TO_W-1 it sets
//   timeout and performs the abort sequence.
//  Not defined: no watchdog logic, timeout tied 0, RUN waits indefinitely.
// TESTING
//  sizes {4,2}, start_req, wr each cycle both ports -> be_done[1] after 2nd wr,
//   be_done[0] after 4th, done_irq one cycle after be_done[0], busy back to 0.
//  sizes {0,0}, start_req at t -> be_start stays 0, done_irq high at t+3.
//  size {3,0}, 3 wr on port0 plus 1 wr on port1 -> err=1, done_irq normal, err
//   cleared by next start_req.
//  sizes {8,8}, abort after 3 wr -> be_start 0 next cycle, be_done=2'b11 pulse,
//   done_irq pulse, busy 0; cfg_we during RUN does not change size.
//  macro on, TO_W=4, size {5,0}, no wr -> timeout=1 and done_irq after 15 RUN
//   cycles; macro off -> busy stays 1 for 100 cycles.
//  areset mid-RUN -> all outputs 0 next cycle, state IDLE, no be_done pulse.

Source files
------------

// File: rtl/mm_run_ctrl_if.sv
// Host and back-end signal bundle for mm_run_ctrl.
// The master side is the host/back-end side and the slave side is the sequencer.
interface mm_run_ctrl_if #(
   parameter int N_OUT = 2,
   parameter int CNT_W = 16
);
   logic             cfg_we;
   logic [2:0]       cfg_sel;
   logic [CNT_W-1:0] cfg_size;
   logic             start_req;
   logic             abort;
   logic             busy;
   logic             done_irq;
   logic             err;
   logic             timeout;
   logic [N_OUT-1:0] be_start;
   logic [N_OUT-1:0] be_done;
   logic [N_OUT-1:0] be_wr;

   modport master (
      output cfg_we, cfg_sel, cfg_size, start_req, abort, be_wr,
      input  busy, done_irq, err, timeout, be_start, be_done
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_size, start_req, abort, be_wr,
      output busy, done_irq, err, timeout, be_start, be_done
   );
endinterface

// File: rtl/mm_run_ctrl.sv
// Output-side run sequencer: starts N_OUT back-ends, counts their writes, signals completion.
// Optional watchdog abort is enabled by defining MM_RUN_TIMEOUT_EN.
module mm_run_ctrl #(
   parameter int N_OUT = 2,
   parameter int CNT_W = 16,
   parameter int TO_W  = 20
) (
   input logic          aclk,
   input logic          areset,
   mm_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] size_cfg [N_OUT];
   logic [CNT_W-1:0] size_act [N_OUT];
   logic [CNT_W-1:0] cnt      [N_OUT];
   logic [N_OUT-1:0] act;
   logic [N_OUT-1:0] cmp;
   logic [N_OUT-1:0] start_q;
   logic [N_OUT-1:0] done_q;
   logic [N_OUT-1:0] open_p;
   logic [N_OUT-1:0] wr_ok;
   logic [N_OUT-1:0] wr_bad;
   logic [N_OUT-1:0] hit;
   logic             err_q;
   logic             to_q;
   logic             stop;
   logic             wd_expire;
   logic             cfg_hit;

   // A port is open while it is part of the run and has not reached its count.
   assign open_p  = act & ~cmp;
   assign wr_ok   = (state == RUN) ? (bus.be_wr & open_p)  : '0;
   assign wr_bad  = (state == RUN) ? (bus.be_wr & ~open_p) : '0;
   assign stop    = (bus.abort && ((state == ARM) || (state == RUN))) || wd_expire;
   assign cfg_hit = bus.cfg_we && (state == IDLE) && (int'(bus.cfg_sel) < N_OUT);

   always_comb begin
      hit = '0;
      for (int i = 0; i < N_OUT; i++) begin
         hit[i] = wr_ok[i] && ((cnt[i] + CNT_W'(1)) == size_act[i]);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // DONE is reached one cycle after the last be_done pulse because cmp is registered.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.start_req) state_nx = ARM;
         ARM:  state_nx = stop ? DONE : RUN;
         RUN:  if (stop || (open_p == '0)) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < N_OUT; i++) begin
            size_cfg[i] <= '0;
            size_act[i] <= '0;
            cnt[i]      <= '0;
         end
         act     <= '0;
         cmp     <= '0;
         start_q <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               for (int i = 0; i < N_OUT; i++) begin
                  if (cfg_hit && (bus.cfg_sel == 3'(i))) size_cfg[i] <= bus.cfg_size;
               end
               if (bus.start_req) begin
                  for (int i = 0; i < N_OUT; i++) begin
                     size_act[i] <= size_cfg[i];
                     cnt[i]      <= '0;
                     act[i]      <= (size_cfg[i] != '0);
                  end
                  cmp   <= '0;
                  err_q <= 1'b0;
               end
            end
            ARM: begin
               start_q <= stop ? '0 : act;
               if (stop) done_q <= open_p;
            end
            RUN: begin
               for (int i = 0; i < N_OUT; i++) begin
                  if (wr_ok[i]) cnt[i] <= cnt[i] + CNT_W'(1);
               end
               cmp     <= cmp | hit;
               start_q <= open_p & ~hit;
               done_q  <= hit;
               if (wr_bad != '0) err_q <= 1'b1;
               if (stop) begin
                  start_q <= '0;
                  done_q  <= open_p;
               end
            end
            DONE: start_q <= '0;
            default: start_q <= '0;
         endcase
      end
   end

`ifdef MM_RUN_TIMEOUT_EN
   logic [TO_W-1:0] wd;

   // Fires on the cycle the idle count would reach all-ones.
   assign wd_expire = (state == RUN) && (wr_ok == '0) && ((wd + TO_W'(1)) == '1);

   always_ff @(posedge aclk) begin
      if (areset) begin
         wd   <= '0;
         to_q <= 1'b0;
      end else begin
         if ((state == IDLE) && bus.start_req) to_q <= 1'b0;
         if ((state != RUN) || (wr_ok != '0)) begin
            wd <= '0;
         end else begin
            wd <= wd + TO_W'(1);
         end
         if (wd_expire) to_q <= 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign to_q      = 1'b0;
`endif

   assign bus.busy     = (state != IDLE);
   assign bus.done_irq = (state == DONE);
   assign bus.err      = err_q;
   assign bus.timeout  = to_q;
   assign bus.be_start = start_q;
   assign bus.be_done  = done_q;

endmodule
